cs_accumulate_resolve: RTL and testbench
========================================

# cs_accumulate_resolve

Sequential carry-save accumulator and resolver. It sits directly downstream of a column array of (m,2)-compressors. Each beat, it absorbs one redundant (sum, carry) vector pair into an internal carry-save state. On the last beat, it resolves that state to a binary result with a chunked multi-cycle carry-propagate adder. The result is presented on a valid/ready output.

## Interface
- `Width`, default 16: result and operand width in bits; all arithmetic is modulo 2^Width.
- `Chunk`, default 4: bits resolved per cycle in RESOLVE; 1 <= Chunk <= Width; the last chunk may be partial.
- `CntWidth`, default 8: width of the beat counter.
- `clk_i`  in  1  clock, all state updates on the rising edge.
- `rst_i`  in  1  reset; one clock; reset is synchronous and active-high.
- `in_valid_i`  in  1  input beat valid.
- `in_ready_o`  out  1  block can accept a beat.
- `in_s_i`  in  Width  sum vector of the compressor array; bit i has weight 2^i.
- `in_c_i`  in  Width  carry vector, already aligned by upstream; bit i has weight 2^i.
- `in_last_i`  in  1  beat is the final operand pair of the accumulation.
- `out_valid_o`  out  1  result valid.
- `out_ready_i`  in  1  downstream accepts the result.
- `out_sum_o`  out  Width  binary result.
- `out_cnt_o`  out  CntWidth  number of beats accumulated, saturating at 2^CntWidth-1.

## Operation
- **State**
  - Registers: carry-save pair `rs`/`rc` (Width each), result register `res`, chunk index, chunk carry bit, counter `cnt`.
  - FSM states: ACC, RESOLVE, OUT.
- **ACC**
  - `in_ready_o` is 1.
  - A beat is accepted when `in_valid_i` and `in_ready_o` are both 1.
  - On accept, `(rs, rc)` <= 4:2 compression of `{rs, rc, in_s_i, in_c_i}`: two full-adder layers, with carries shifted left by one. Bits shifted out above Width are discarded.
  - On accept, `cnt` increments, saturating.
  - Accept with `in_last_i`=1 moves to RESOLVE, with chunk index 0 and chunk carry 0.
- **RESOLVE**
  - `in_ready_o` is 0.
  - Each cycle, `res[k*Chunk +: Chunk]` <= chunk of `rs` + chunk of `rc` + chunk carry, and the chunk carry-out is stored.
  - After chunk N-1, where N = ceil(Width/Chunk), the FSM moves to OUT. The final carry-out is discarded.
- **OUT**
  - `out_valid_o` is 1. `out_sum_o` equals `res` and `out_cnt_o` equals `cnt`; both are stable while `out_valid_o` is 1.
  - `in_ready_o` is 0, and `in_valid_i` is ignored.
  - When `out_ready_i`=1, the FSM moves to ACC and clears `rs`, `rc`, and `cnt` to 0.
- **Combinational outputs**
  - `out_sum_o` and `out_cnt_o` are driven from registers.
  - `out_valid_o` and `in_ready_o` are decoded from the FSM state only, with no combinational path from the inputs.
- **Reset**
  - While `rst_i` is 1: `in_ready_o`=0, `out_valid_o`=0, `out_sum_o`=0, `out_cnt_o`=0.
  - On the next edge, all registers are cleared and the FSM enters ACC.
  - Reset in any state, including mid-RESOLVE or OUT, aborts the operation. No partial result is ever presented.
- **Boundary cases**
  - `in_last_i` on the first beat is legal; the result is `in_s_i` + `in_c_i`.
  - A beat that is not accepted has no effect.
  - When `cnt` is saturated, further beats still accumulate into `rs`/`rc`.

## Timing
- Last beat accepted at edge t: RESOLVE occupies cycles t+1 .. t+N, and `out_valid_o` rises in cycle t+N+1. For Width=16, Chunk=4, `out_valid_o` is 1 five cycles after the accept edge.
- Output handshake at edge u: `in_ready_o` is 1 in cycle u+1.
- Throughput:
  - 1 beat/cycle in ACC.
  - One result every N+2 cycles minimum, for a single-beat accumulation with `out_ready_i` held at 1.

## Configuration
- `CS_RESOLVE_FAST_EN` defined: RESOLVE is a single full-Width carry-propagate add completed in one cycle (N=1); `Chunk` is ignored. `out_valid_o` rises in cycle t+2.
- `CS_RESOLVE_FAST_EN` not defined: chunked resolve as described above.

## Test plan
All scenarios use Width=16, Chunk=4 unless stated.
- **Single beat:** one beat s=0x1234, c=0x0001, last=1 -> `out_sum_o`=0x1235, `out_cnt_o`=1; `out_valid_o` rises exactly 5 cycles after the accept edge (2 cycles with `CS_RESOLVE_FAST_EN`).
- **Multi-beat with wrap:** beats (0x00FF,0x0001), (0x0F00,0x0100), (0x8000,0x8000, last) -> `out_sum_o`=0x1100, `out_cnt_o`=3.
- **Carry across all chunks:** s=0xFFFF, c=0x0001, last -> `out_sum_o`=0x0000; the chunk carry propagates through all 4 chunks.
- **Output backpressure:** `out_ready_i`=0 for 10 cycles in OUT with `in_valid_i`=1 -> `out_valid_o` stays 1, `out_sum_o` is stable, `in_ready_o`=0, and no beat is absorbed. Then handshake, then a single beat (0x0003,0x0004,last) -> 0x0007, `out_cnt_o`=1.
- **Reset mid-RESOLVE:** assert `rst_i` 2 cycles into RESOLVE -> next cycle `in_ready_o`=1, `out_valid_o`=0; a following beat (0x0010,0x0000,last) yields 0x0010.
- **Counter saturation:** CntWidth=2, five beats of (0x0001,0x0000), last on the fifth -> `out_cnt_o`=3, `out_sum_o`=0x0005.

Source files
------------

// File: rtl/cs_accumulate_resolve.sv
// cs_accumulate_resolve
// Carry-save accumulator with a multi-cycle chunked carry-propagate resolver.
// Each accepted beat folds a redundant (sum, carry) pair into the running
// carry-save state with a 4:2 compressor. The last beat triggers a resolve
// that walks the state Chunk bits per cycle into a binary result. The result
// is held on a valid/ready output until it is taken.
// Optional build macro: CS_RESOLVE_FAST_EN -- resolve in one full-width add.
module cs_accumulate_resolve #(
  parameter int Width    = 16,
  parameter int Chunk    = 4,
  parameter int CntWidth = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                in_valid_i,
  output logic                in_ready_o,
  input  logic [Width-1:0]    in_s_i,
  input  logic [Width-1:0]    in_c_i,
  input  logic                in_last_i,
  output logic                out_valid_o,
  input  logic                out_ready_i,
  output logic [Width-1:0]    out_sum_o,
  output logic [CntWidth-1:0] out_cnt_o
);

  localparam int N    = (Width + Chunk - 1) / Chunk;
  localparam int PadW = N * Chunk;
  localparam int IdxW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {ACC, RESOLVE, OUT} state_e;

  state_e              state_q, state_d;
  logic [Width-1:0]    rs_q, rs_d;
  logic [Width-1:0]    rc_q, rc_d;
  logic [PadW-1:0]     res_q, res_d;
  logic [CntWidth-1:0] cnt_q, cnt_d;

  // Two full-adder layers; carries shift up one bit and overflow is dropped,
  // so the represented value stays exact modulo 2^Width.
  function automatic logic [2*Width-1:0] compress42(input logic [Width-1:0] a,
                                                    input logic [Width-1:0] b,
                                                    input logic [Width-1:0] c,
                                                    input logic [Width-1:0] d);
    logic [Width-1:0] s1, c1, s2, c2;
    s1 = a ^ b ^ c;
    c1 = ((a & b) | (a & c) | (b & c)) << 1;
    s2 = s1 ^ c1 ^ d;
    c2 = ((s1 & c1) | (s1 & d) | (c1 & d)) << 1;
    return {s2, c2};
  endfunction

  // Beat counter sticks at all-ones instead of wrapping.
  function automatic logic [CntWidth-1:0] sat_inc(input logic [CntWidth-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

`ifndef CS_RESOLVE_FAST_EN
  logic [IdxW-1:0] idx_q, idx_d;
  logic            cy_q, cy_d;
  logic [PadW-1:0] rs_pad, rc_pad;
  logic [Chunk:0]  chunk_sum;
  int              base;

  // Zero-pad the state so a partial top chunk reads as zeros above Width.
  assign rs_pad = PadW'(rs_q);
  assign rc_pad = PadW'(rc_q);
  assign base   = int'(idx_q) * Chunk;

  // Current chunk of the carry-propagate add, including the carry from below.
  always_comb begin
    chunk_sum = {1'b0, rs_pad[base +: Chunk]} + {1'b0, rc_pad[base +: Chunk]}
              + {{Chunk{1'b0}}, cy_q};
  end
`endif

  // Next-state and datapath update for the ACC / RESOLVE / OUT sequence.
  always_comb begin
    state_d = state_q;
    rs_d    = rs_q;
    rc_d    = rc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
`ifndef CS_RESOLVE_FAST_EN
    idx_d   = idx_q;
    cy_d    = cy_q;
`endif
    case (state_q)
      ACC: begin
        if (in_valid_i) begin
          {rs_d, rc_d} = compress42(rs_q, rc_q, in_s_i, in_c_i);
          cnt_d        = sat_inc(cnt_q);
          if (in_last_i) begin
            state_d = RESOLVE;
`ifndef CS_RESOLVE_FAST_EN
            idx_d   = '0;
            cy_d    = 1'b0;
`endif
          end
        end
      end
      RESOLVE: begin
`ifdef CS_RESOLVE_FAST_EN
        res_d   = PadW'(rs_q + rc_q);
        state_d = OUT;
`else
        res_d[base +: Chunk] = chunk_sum[Chunk-1:0];
        cy_d                 = chunk_sum[Chunk];
        if (idx_q == IdxW'(N - 1)) begin
          state_d = OUT;
        end else begin
          idx_d = idx_q + 1'b1;
        end
`endif
      end
      OUT: begin
        if (out_ready_i) begin
          state_d = ACC;
          rs_d    = '0;
          rc_d    = '0;
          cnt_d   = '0;
        end
      end
      default: state_d = ACC;
    endcase
  end

  // State registers; reset clears everything and returns to ACC.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ACC;
      rs_q    <= '0;
      rc_q    <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
`ifndef CS_RESOLVE_FAST_EN
      idx_q   <= '0;
      cy_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      rs_q    <= rs_d;
      rc_q    <= rc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
`ifndef CS_RESOLVE_FAST_EN
      idx_q   <= idx_d;
      cy_q    <= cy_d;
`endif
    end
  end

  // Handshake flags come from the state register; reset forces every output
  // low immediately so nothing is presented before the first reset edge.
  assign in_ready_o  = ~rst_i & (state_q == ACC);
  assign out_valid_o = ~rst_i & (state_q == OUT);
  assign out_sum_o   = rst_i ? '0 : res_q[Width-1:0];
  assign out_cnt_o   = rst_i ? '0 : cnt_q;

endmodule

// File: tb/tb_cs_accumulate_resolve.sv
// Testbench for cs_accumulate_resolve: directed scenarios followed by random
// multi-beat accumulations, compared against a plain arithmetic model.
module tb_cs_accumulate_resolve;
  localparam int W    = 16;
  localparam int CH   = 4;
  localparam int CW   = 2;
  localparam int NCH  = (W + CH - 1) / CH;
`ifdef CS_RESOLVE_FAST_EN
  localparam int LAT  = 2;
`else
  localparam int LAT  = NCH + 1;
`endif
  localparam int MAXC = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, in_last;
  logic          out_valid, out_ready;
  logic [W-1:0]  in_s, in_c, out_sum;
  logic [CW-1:0] out_cnt;

  int           checks = 0;
  int           errors = 0;
  logic [W-1:0] m_sum;
  int           m_cnt;

  always #5 clk = ~clk;

  cs_accumulate_resolve #(.Width(W), .Chunk(CH), .CntWidth(CW)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_s_i     (in_s),
    .in_c_i     (in_c),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_sum_o  (out_sum),
    .out_cnt_o  (out_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Model: the result is simply the modular sum of every accepted s and c.
  task automatic model_clear();
    m_sum = '0;
    m_cnt = 0;
  endtask

  task automatic beat(input logic [W-1:0] s, input logic [W-1:0] c, input logic last);
    int w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    check("beat_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_s     = s;
    in_c     = c;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_s     = W'($urandom);
    in_c     = W'($urandom);
    in_last  = 1'b1;
    m_sum    = m_sum + s + c;
    if (m_cnt < MAXC) m_cnt++;
  endtask

  // Called right after the last beat's accept edge.
  task automatic expect_result(input string tag);
    int lat = 1;
    check({tag, "_busy_ready"}, 32'(in_ready), 32'd0);
    while (!out_valid && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(LAT));
    check({tag, "_sum"}, 32'(out_sum), 32'(m_sum));
    check({tag, "_cnt"}, 32'(out_cnt), 32'(m_cnt));
  endtask

  task automatic take();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("take_in_ready", 32'(in_ready), 32'd1);
    check("take_out_valid", 32'(out_valid), 32'd0);
    model_clear();
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_last   = 1'b0;
    in_s      = '0;
    in_c      = '0;
    out_ready = 1'b0;
    model_clear();
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cnt", 32'(out_cnt), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);

    // Single beat, then output backpressure with input traffic offered.
    beat(16'h1234, 16'h0001, 1'b1);
    expect_result("single");
    check("single_const", 32'(out_sum), 32'h1235);
    in_valid = 1'b1;
    in_last  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_s = W'($urandom);
      in_c = W'($urandom);
      tick();
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_sum", 32'(out_sum), 32'h1235);
      check("bp_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid = 1'b0;
    take();
    beat(16'h0003, 16'h0004, 1'b1);
    expect_result("after_bp");
    check("after_bp_const", 32'(out_sum), 32'h0007);
    take();

    // Multi-beat accumulation with modular wrap.
    beat(16'h00FF, 16'h0001, 1'b0);
    beat(16'h0F00, 16'h0100, 1'b0);
    beat(16'h8000, 16'h8000, 1'b1);
    expect_result("multi");
    check("multi_const", 32'(out_sum), 32'h1100);
    take();

    // Carry ripples through every chunk.
    beat(16'hFFFF, 16'h0001, 1'b1);
    expect_result("carry_all");
    check("carry_all_const", 32'(out_sum), 32'h0000);
    take();

    // Reset two cycles into the resolve aborts the result.
    beat(16'hABCD, 16'h1111, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out_sum", 32'(out_sum), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("after_rst_in_ready", 32'(in_ready), 32'd1);
    check("after_rst_out_valid", 32'(out_valid), 32'd0);
    check("after_rst_out_cnt", 32'(out_cnt), 32'd0);
    model_clear();
    beat(16'h0010, 16'h0000, 1'b1);
    expect_result("after_rst");
    check("after_rst_const", 32'(out_sum), 32'h0010);
    take();

    // Counter saturates while accumulation continues.
    for (int i = 0; i < 5; i++) beat(16'h0001, 16'h0000, (i == 4));
    expect_result("sat");
    check("sat_sum_const", 32'(out_sum), 32'h0005);
    check("sat_cnt_const", 32'(out_cnt), 32'(MAXC));
    take();

    // Random accumulations with idle gaps and random output stalls.
    for (int t = 0; t < 25; t++) begin
      int nb = $urandom_range(1, 6);
      for (int b = 0; b < nb; b++) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_s     = W'($urandom);
          in_c     = W'($urandom);
          tick();
        end
        beat(W'($urandom), W'($urandom), (b == nb - 1));
      end
      expect_result("rand");
      repeat ($urandom_range(0, 3)) begin
        in_valid = $urandom_range(0, 1) == 1;
        in_s     = W'($urandom);
        in_c     = W'($urandom);
        tick();
        check("rand_hold_sum", 32'(out_sum), 32'(m_sum));
      end
      in_valid = 1'b0;
      take();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
